cselector_n_cache: RTL and testbench
====================================

Name: cselector_n_cache

Overview:
Clocked, parametrised N-way conditional-fork selector for the cache-replacement control path, with drive/free pulse handshakes.
- Upstream issues a drive pulse; the block fires and acknowledges it, then latches the per-channel valid mask internally.
- After a programmable delay, it drives only the selected downstream channels.
- It waits for the selected channels to return free before it accepts the next token.
- Adds over the 2-way version: N channels, cycle-programmable delay, internal valid latching, an empty-mask bypass, and overrun detection.

Parameters:
N_OUT, 4, number of downstream channels (2..16).
DELAY, 8, cycles from o_fire to o_driveNext (1..255).
CNT_W, 8, delay counter width; must satisfy 2^CNT_W > DELAY.

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous active-high reset.
i_drive  input  1  upstream request pulse (1 cycle).
o_free  output  1  upstream acknowledge pulse.
o_fire  output  1  fire pulse; marks the valid-capture point.
i_valid  input  N_OUT  channel select mask, sampled on the accepted i_drive cycle.
o_driveNext  output  N_OUT  per-channel downstream drive pulses.
i_freeNext  input  N_OUT  per-channel downstream free pulses.
o_busy  output  1  high whenever state != IDLE.
o_overrun  output  1  sticky; set when i_drive arrives while busy.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, counter=0, latched mask=0, collected-free bits=0.
  - All outputs 0, including o_overrun.
  - Reset mid-operation aborts the token silently; no driveNext is emitted.
- State machine: IDLE -> FIRE -> DELAY -> WAIT_FREE -> IDLE.
- IDLE:
  - i_drive=1 at cycle t: latch i_valid into sel_q and go to FIRE.
  - All other inputs are ignored.
- FIRE (cycle t+1):
  - o_fire=1 and o_free=1 for exactly this cycle.
  - Load counter with DELAY-1 and go to DELAY.
- DELAY:
  - Decrement the counter each cycle. When counter==0:
    - If sel_q != 0: o_driveNext = sel_q for one cycle (cycle t+1+DELAY), then go to WAIT_FREE.
    - If sel_q == 0: no driveNext; go to IDLE (empty-mask bypass; the token completes with no wait).
  - With DELAY=1, driveNext appears at cycle t+2.
- WAIT_FREE:
  - Default join is OR over selected channels: any i_freeNext[i] with sel_q[i]=1 completes the token.
  - On completion, go to IDLE the next cycle.
  - i_freeNext on unselected channels is ignored.
- Free outside WAIT_FREE is ignored:
  - i_freeNext during FIRE or DELAY, including the driveNext cycle itself, is ignored.
  - Downstream must respond at least one cycle after driveNext.
- i_drive in any state other than IDLE, including the completion cycle:
  - The pulse is dropped and no handshake is produced.
  - o_overrun is set to 1 and stays high until reset.
- Multiple bits in sel_q: all selected channels are driven in the same cycle (fork).
- o_driveNext bits are never high outside the single drive cycle.
- Exactly one o_fire and one o_free per accepted drive.
- Minimum token period with OR join: DELAY+3 cycles (drive at t, free at t+DELAY+2, IDLE at t+DELAY+3).
- All outputs are registered; no combinational path from input to output.

Optional Feature:
CSEL_JOIN_ALL_EN
- Defined: WAIT_FREE uses AND-join.
  - A per-channel sticky collected register records i_freeNext[i] for each selected i.
  - The token completes when collected == sel_q. Free pulses may arrive in different cycles.
  - Repeated frees on the same channel are harmless.
  - collected clears on entry to IDLE.
- Undefined: OR-join as described in Behaviour; no collected register is synthesised.

Test Plan:
- DELAY=8, N_OUT=4: i_drive at cycle 10, i_valid=4'b0100 -> o_fire/o_free at cycle 11; o_driveNext=4'b0100 at 19 only; i_freeNext[2] at 22 -> o_busy low from 23.
- i_valid=4'b0000 with drive at 10 -> o_fire at 11, no driveNext, o_busy low at 20, no free required.
- i_valid=4'b1010, i_freeNext[0] pulse at 22 (unselected) -> still busy; i_freeNext[3] at 25 -> IDLE at 26. With CSEL_JOIN_ALL_EN: also needs i_freeNext[1]; frees at 25 and 30 -> IDLE at 31.
- Second i_drive at cycle 14 during DELAY -> no extra o_fire; o_overrun=1 from 15 onward; first token completes normally.
- i_valid changes at 11..18 after drive at 10 -> driveNext still reflects the mask sampled at 10.
- rst pulse at cycle 15 during DELAY -> outputs 0 immediately; no driveNext at 19; new drive at 20 -> o_fire at 21.

Source files
------------

// File: rtl/cselector_n_cache_if.sv
// Handshake bundle for cselector_n_cache: upstream drive/free pulses plus the
// per-channel downstream drive/free vectors and status flags.
interface cselector_n_cache_if #(
    parameter int unsigned N_OUT = 4
);
    logic             i_drive;
    logic             o_free;
    logic             o_fire;
    logic [N_OUT-1:0] i_valid;
    logic [N_OUT-1:0] o_drive_next;
    logic [N_OUT-1:0] i_free_next;
    logic             o_busy;
    logic             o_overrun;

    modport master (
        output i_drive, i_valid, i_free_next,
        input  o_free, o_fire, o_drive_next, o_busy, o_overrun
    );

    modport slave (
        input  i_drive, i_valid, i_free_next,
        output o_free, o_fire, o_drive_next, o_busy, o_overrun
    );
endinterface

// File: rtl/cselector_n_cache.sv
// N-way conditional-fork selector with programmable fire-to-drive delay.
// Define CSEL_JOIN_ALL_EN to complete a token only after every selected channel frees (AND-join).
module cselector_n_cache #(
    parameter int unsigned N_OUT = 4,
    parameter int unsigned DELAY = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    cselector_n_cache_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_DELAY = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [N_OUT-1:0] sel, sel_n;
    logic [N_OUT-1:0] drv_n;
    logic             fire_n;
    logic             busy_n;
    logic             ovr_n;
`ifdef CSEL_JOIN_ALL_EN
    logic [N_OUT-1:0] coll, coll_n;
`endif

    // Next-state, datapath and next-output decode; outputs are registered from these.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
`ifdef CSEL_JOIN_ALL_EN
        coll_n  = coll;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.i_drive) begin
                    sel_n   = bus.i_valid;
                    state_n = ST_FIRE;
                end
            end
            ST_FIRE: begin
                cnt_n   = CNT_LOAD;
                state_n = ST_DELAY;
            end
            ST_DELAY: begin
                if (cnt == '0) begin
                    state_n = (sel != '0) ? ST_WAIT : ST_IDLE;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            ST_WAIT: begin
`ifdef CSEL_JOIN_ALL_EN
                coll_n = coll | (bus.i_free_next & sel);
                if (coll_n == sel) begin
                    state_n = ST_IDLE;
                end
`else
                if ((bus.i_free_next & sel) != '0) begin
                    state_n = ST_IDLE;
                end
`endif
            end
            default: state_n = ST_IDLE;
        endcase
`ifdef CSEL_JOIN_ALL_EN
        if (state_n == ST_IDLE) begin
            coll_n = '0;
        end
`endif
        // Drive cycle is the DELAY cycle whose counter reads zero.
        drv_n  = (state_n == ST_DELAY && cnt_n == '0) ? sel_n : '0;
        fire_n = (state_n == ST_FIRE);
        busy_n = (state_n != ST_IDLE);
        ovr_n  = bus.o_overrun | (bus.i_drive && state != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            sel              <= '0;
`ifdef CSEL_JOIN_ALL_EN
            coll             <= '0;
`endif
            bus.o_fire       <= 1'b0;
            bus.o_free       <= 1'b0;
            bus.o_drive_next <= '0;
            bus.o_busy       <= 1'b0;
            bus.o_overrun    <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            sel              <= sel_n;
`ifdef CSEL_JOIN_ALL_EN
            coll             <= coll_n;
`endif
            bus.o_fire       <= fire_n;
            bus.o_free       <= fire_n;
            bus.o_drive_next <= drv_n;
            bus.o_busy       <= busy_n;
            bus.o_overrun    <= ovr_n;
        end
    end

endmodule

// File: tb/tb_cselector_n_cache.sv
// Directed bench for cselector_n_cache (N_OUT=4, DELAY=8); cycle k is the period after the k-th
// rising edge following reset release, inputs set 1ns after the edge, outputs sampled on the falling edge.
module tb_cselector_n_cache;

    localparam int unsigned N = 4;
    localparam int unsigned D = 8;
    localparam int          LAST_CYC = 34;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cselector_n_cache_if #(.N_OUT(N)) bus ();

    cselector_n_cache #(.N_OUT(N), .DELAY(D), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] valid;
        int         fc0;
        logic [3:0] fm0;
        int         fc1;
        logic [3:0] fm1;
        int         fc2;
        logic [3:0] fm2;
        int         exp_drv;
        int         exp_idle;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input int c, input logic fire, input logic [3:0] drv,
                               input logic busy, input logic ovr);
        chk({tag, ".fire"},    c, 32'(bus.o_fire),       32'(fire));
        chk({tag, ".free"},    c, 32'(bus.o_free),       32'(fire));
        chk({tag, ".drv"},     c, 32'(bus.o_drive_next), 32'(drv));
        chk({tag, ".busy"},    c, 32'(bus.o_busy),       32'(busy));
        chk({tag, ".overrun"}, c, 32'(bus.o_overrun),    32'(ovr));
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.i_drive     = 1'b0;
        bus.i_valid     = '0;
        bus.i_free_next = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cycle("reset", -1, 1'b0, 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // valid, frees (cycle, mask) x3, expected drive cycle, expected first idle cycle
`ifdef CSEL_JOIN_ALL_EN
        vecs[0] = '{4'b0100, 22, 4'b0100, -1, 4'b0000, -1, 4'b0000, 19, 23};
        vecs[1] = '{4'b0000, -1, 4'b0000, -1, 4'b0000, -1, 4'b0000, 19, 20};
        vecs[2] = '{4'b1010, 22, 4'b0001, 25, 4'b1000, 30, 4'b0010, 19, 31};
        vecs[3] = '{4'b1111, 19, 4'b1111, 20, 4'b0001, 24, 4'b1110, 19, 25};
        vecs[4] = '{4'b0011, 15, 4'b0011, 21, 4'b0010, 23, 4'b0001, 19, 24};
`else
        vecs[0] = '{4'b0100, 22, 4'b0100, -1, 4'b0000, -1, 4'b0000, 19, 23};
        vecs[1] = '{4'b0000, -1, 4'b0000, -1, 4'b0000, -1, 4'b0000, 19, 20};
        vecs[2] = '{4'b1010, 22, 4'b0001, 25, 4'b1000, 30, 4'b0010, 19, 26};
        vecs[3] = '{4'b1111, 19, 4'b1111, 20, 4'b0001, 24, 4'b1110, 19, 21};
        vecs[4] = '{4'b0011, 15, 4'b0011, 21, 4'b0010, 23, 4'b0001, 19, 22};
`endif

        // Table vectors: one token per entry, drive at cycle 10, mask scrambled on other cycles.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int c = 0; c <= LAST_CYC; c++) begin
                logic [3:0] fm;
                @(posedge clk);
                #1;
                fm = 4'b0000;
                if (c == vecs[v].fc0) fm = fm | vecs[v].fm0;
                if (c == vecs[v].fc1) fm = fm | vecs[v].fm1;
                if (c == vecs[v].fc2) fm = fm | vecs[v].fm2;
                bus.i_drive     = (c == 10);
                bus.i_valid     = (c == 10) ? vecs[v].valid : 4'($urandom);
                bus.i_free_next = fm;
                @(negedge clk);
                check_cycle($sformatf("vec%0d", v), c, c == 11,
                            (c == vecs[v].exp_drv) ? vecs[v].valid : 4'b0000,
                            (c >= 11) && (c < vecs[v].exp_idle), 1'b0);
            end
        end

        // Overrun: second drive during DELAY is dropped, flag sticks, first token finishes.
        do_reset();
        for (int c = 0; c <= LAST_CYC; c++) begin
            @(posedge clk);
            #1;
            bus.i_drive     = (c == 10) || (c == 14);
            bus.i_valid     = (c == 10) ? 4'b0100 : 4'($urandom);
            bus.i_free_next = (c == 22) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            check_cycle("ovr", c, c == 11, (c == 19) ? 4'b0100 : 4'b0000,
                        (c >= 11) && (c < 23), c >= 15);
        end

        // Reset mid-DELAY aborts the token; a fresh drive afterwards runs normally.
        do_reset();
        for (int c = 0; c <= LAST_CYC; c++) begin
            @(posedge clk);
            #1;
            if (c == 15) rst = 1'b1;
            if (c == 16) rst = 1'b0;
            bus.i_drive     = (c == 10) || (c == 20);
            bus.i_valid     = (c == 10) ? 4'b0110 : (c == 20) ? 4'b0001 : 4'($urandom);
            bus.i_free_next = (c == 30) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            check_cycle("rst", c, (c == 11) || (c == 21), (c == 29) ? 4'b0001 : 4'b0000,
                        ((c >= 11) && (c < 15)) || ((c >= 21) && (c < 31)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
